// File: rtl/buzzer_pkg.sv
// Shared constants and helpers for the buzzer output block: register map,
// tone divisor table, one-shot lengths and envelope step lengths.
package buzzer_pkg;

  localparam logic [11:0] BUZZER_R4_ADDR   = 12'hF54;
  localparam logic [11:0] BUZZER_FREQ_ADDR = 12'hF74;
  localparam logic [11:0] BUZZER_CTRL_ADDR = 12'hF75;

  localparam logic [12:0] SHOT_LEN_SHORT = 13'd1024;
  localparam logic [12:0] SHOT_LEN_LONG  = 13'd4096;

  localparam logic [12:0] ENV_STEP_SHORT = 13'd2048;
  localparam logic [12:0] ENV_STEP_LONG  = 13'd4096;

  typedef struct packed {
    logic       enrtm;
    logic [2:0] bzfq;
    logic       shtpw;
    logic       enon;
  } bz_ctrl_t;

  // Tone period in 32 kHz ticks for each bzfq code (4096 Hz down to 1170 Hz).
  function automatic logic [4:0] bz_divisor(input logic [2:0] f);
    case (f)
      3'd0:    bz_divisor = 5'd8;
      3'd1:    bz_divisor = 5'd10;
      3'd2:    bz_divisor = 5'd12;
      3'd3:    bz_divisor = 5'd14;
      3'd4:    bz_divisor = 5'd16;
      3'd5:    bz_divisor = 5'd20;
      3'd6:    bz_divisor = 5'd24;
      default: bz_divisor = 5'd28;
    endcase
  endfunction

endpackage

// File: rtl/buzzer_output_if.sv
// Core data-bus view of the buzzer output block: address, write strobe/data,
// combinational read data and hit.
interface buzzer_output_if;
  logic [11:0] bus_addr;
  logic        bus_write_en;
  logic [3:0]  bus_write_data;
  logic [3:0]  bus_read_data;
  logic        bus_read_hit;

  modport master (
    output bus_addr, bus_write_en, bus_write_data,
    input  bus_read_data, bus_read_hit
  );

  modport slave (
    input  bus_addr, bus_write_en, bus_write_data,
    output bus_read_data, bus_read_hit
  );
endinterface

// File: rtl/buzzer_envelope.sv
// Buzzer envelope: counts 32 kHz ticks while sounding and raises a 3-bit
// attenuation level every 2048/4096 ticks, saturating at 7.
module buzzer_envelope
  import buzzer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_tick,
  input  logic       i_run,
  input  logic       i_enon,
  input  logic       i_enrtm,
  input  logic       i_restart,
  output logic [2:0] o_level
);

  logic [12:0] r_step;
  logic [2:0]  r_level;
  logic [12:0] w_limit;

  assign w_limit = i_enrtm ? ENV_STEP_LONG : ENV_STEP_SHORT;
  assign o_level = i_enon ? r_level : 3'd0;

  // Restart has priority over a coincident step so ENRST always lands at level 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step  <= '0;
      r_level <= '0;
    end else if (!i_enon || i_restart) begin
      r_step  <= '0;
      r_level <= '0;
    end else if (i_run && i_tick) begin
      if (r_step == w_limit - 13'd1) begin
        r_step <= '0;
        if (r_level != 3'd7) r_level <= r_level + 3'd1;
      end else begin
        r_step <= r_step + 13'd1;
      end
    end
  end

endmodule

// File: rtl/buzzer_output.sv
// R4 output register plus E0C6S46-style buzzer: register file, one-shot timer,
// phase/duty tone generator and bus read mux.
module buzzer_output
  import buzzer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_32k_en,
  buzzer_output_if.slave    bus,
  output logic [3:0]        output_r4,
  output logic              buzzer_out
);

  logic [3:0]  r_r4;
  bz_ctrl_t    r_ctrl;
  logic        r_busy;
  logic [12:0] r_shot_cnt;
  logic [4:0]  r_phase;
  logic [4:0]  r_period;
  logic        r_sounding_d;
  logic        r_buzz;

  logic        w_wr_r4, w_wr_freq, w_wr_ctrl;
  logic        w_shot_trig, w_enrst;
  logic        w_sounding, w_restart;
  logic [2:0]  w_level;
  logic [4:0]  w_p, w_h_raw, w_h;
  logic [3:0]  w_weight;
  logic [8:0]  w_prod;

  assign w_wr_r4   = bus.bus_write_en && (bus.bus_addr == BUZZER_R4_ADDR);
  assign w_wr_freq = bus.bus_write_en && (bus.bus_addr == BUZZER_FREQ_ADDR);
  assign w_wr_ctrl = bus.bus_write_en && (bus.bus_addr == BUZZER_CTRL_ADDR);

  // SHOT only fires when R43 masks the continuous buzz.
  assign w_shot_trig = w_wr_ctrl && bus.bus_write_data[3] && r_r4[3];
  assign w_enrst     = w_wr_ctrl && bus.bus_write_data[1];

  assign w_sounding = !r_r4[3] || r_busy;
  assign w_restart  = (w_sounding && !r_sounding_d) || w_enrst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_r4         <= 4'b1000;
      r_ctrl       <= '0;
      r_sounding_d <= 1'b0;
    end else begin
      r_sounding_d <= w_sounding;
      if (w_wr_r4)   r_r4 <= bus.bus_write_data;
      if (w_wr_freq) {r_ctrl.enrtm, r_ctrl.bzfq} <= bus.bus_write_data;
      if (w_wr_ctrl) begin
        r_ctrl.shtpw <= bus.bus_write_data[2];
        r_ctrl.enon  <= bus.bus_write_data[0];
      end
    end
  end

  // One-shot; the pulse width comes from the SHTPW bit of the same write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= 1'b0;
      r_shot_cnt <= '0;
    end else if (w_wr_r4 && !bus.bus_write_data[3]) begin
      r_busy     <= 1'b0;
      r_shot_cnt <= '0;
    end else if (w_shot_trig) begin
      r_busy     <= 1'b1;
      r_shot_cnt <= bus.bus_write_data[2] ? SHOT_LEN_LONG : SHOT_LEN_SHORT;
    end else if (r_busy && clk_32k_en) begin
      r_shot_cnt <= r_shot_cnt - 13'd1;
      if (r_shot_cnt == 13'd1) r_busy <= 1'b0;
    end
  end

  buzzer_envelope u_env (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_tick    (clk_32k_en),
    .i_run     (w_sounding),
    .i_enon    (r_ctrl.enon),
    .i_enrtm   (r_ctrl.enrtm),
    .i_restart (w_restart),
    .o_level   (w_level)
  );

  // The period is sampled at phase 0 so a bzfq change never truncates a cycle.
  assign w_p      = (r_phase == 5'd0) ? bz_divisor(r_ctrl.bzfq) : r_period;
  assign w_weight = 4'd8 - {1'b0, w_level};
  assign w_prod   = {4'd0, w_p} * {5'd0, w_weight};
  assign w_h_raw  = 5'(w_prod >> 4);
  assign w_h      = (w_h_raw == 5'd0) ? 5'd1 : w_h_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase  <= '0;
      r_period <= '0;
      r_buzz   <= 1'b0;
    end else if (!w_sounding) begin
      r_phase <= '0;
      r_buzz  <= 1'b0;
    end else if (clk_32k_en) begin
      r_buzz <= (r_phase < w_h);
      if (r_phase == 5'd0) r_period <= w_p;
      r_phase <= (r_phase == w_p - 5'd1) ? 5'd0 : r_phase + 5'd1;
    end
  end

  always_comb begin
    bus.bus_read_data = 4'd0;
    bus.bus_read_hit  = 1'b0;
    case (bus.bus_addr)
      BUZZER_R4_ADDR: begin
        bus.bus_read_data = r_r4;
        bus.bus_read_hit  = 1'b1;
      end
      BUZZER_FREQ_ADDR: begin
        bus.bus_read_data = {r_ctrl.enrtm, r_ctrl.bzfq};
        bus.bus_read_hit  = 1'b1;
      end
      BUZZER_CTRL_ADDR: begin
        bus.bus_read_data = {r_busy, r_ctrl.shtpw, 1'b0, r_ctrl.enon};
        bus.bus_read_hit  = 1'b1;
      end
      default: ;
    endcase
  end

  assign output_r4  = r_r4;
  assign buzzer_out = r_buzz;

endmodule

// File: tb/tb_buzzer_output.sv
// Scoreboard bench for buzzer_output: expected reads/levels and expected
// high/low run lengths are queued by the stimulus and popped by monitors.
module tb_buzzer_output;
  import buzzer_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_32k_en = 1'b0;
  logic [3:0] output_r4;
  logic       buzzer_out;

  buzzer_output_if bus ();

  buzzer_output dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_32k_en (clk_32k_en),
    .bus        (bus.slave),
    .output_r4  (output_r4),
    .buzzer_out (buzzer_out)
  );

  always #5 clk = ~clk;

  // One tick every second clk.
  initial forever begin
    @(negedge clk);
    clk_32k_en = ~clk_32k_en;
  end

  typedef struct { string name; int sel; int exp; } chk_t;
  typedef struct { string name; bit val; int len; } run_t;

  chk_t chk_q[$];
  run_t run_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hi_ticks = 0;
  int   sync_gen = 0;
  int   seen_gen = 0;
  bit   discard = 0;
  bit   cur_val = 0;
  int   cur_len = 0;
  logic chk_req = 1'b0;

  // Point checks, compared on pre-edge values.
  always @(posedge clk) begin : mon_chk
    chk_t c;
    int   act;
    if (chk_req) begin
      if (chk_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL chk_queue_empty");
      end else begin
        c = chk_q.pop_front();
        case (c.sel)
          0:       act = int'(bus.bus_read_data);
          1:       act = int'(bus.bus_read_hit);
          2:       act = int'(buzzer_out);
          3:       act = int'(output_r4);
          default: act = hi_ticks;
        endcase
        n_cmp++;
        if (act != c.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d required %0d", c.name, act, c.exp);
        end
      end
    end
  end

  // Per-tick waveform sampler; completed runs are matched against run_q.
  always @(posedge clk) begin : mon_run
    run_t r;
    bit   v;
    if (clk_32k_en === 1'b1) begin
      @(negedge clk);
      v = buzzer_out;
      if (v) hi_ticks++;
      if (seen_gen != sync_gen) begin
        seen_gen = sync_gen;
        discard  = 1;
      end
      if (v == cur_val) begin
        cur_len++;
      end else begin
        if (discard) discard = 0;
        else if (run_q.size() > 0) begin
          r = run_q.pop_front();
          n_cmp++;
          if (r.val != cur_val || r.len != cur_len) begin
            n_bad++;
            $display("FAIL %s: got level %0d for %0d ticks, required level %0d for %0d ticks",
                     r.name, cur_val, cur_len, r.val, r.len);
          end
        end
        cur_val = v;
        cur_len = 1;
      end
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (clk_32k_en !== 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic wait_level(input logic v);
    int i = 0;
    while (buzzer_out !== v && i < 200) begin
      wait_tick();
      i++;
    end
    if (buzzer_out !== v) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_level: buzzer_out %b, required %b", buzzer_out, v);
    end
  endtask

  task automatic wait_rise();
    wait_level(1'b0);
    wait_level(1'b1);
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] d);
    bus.bus_addr       = a;
    bus.bus_write_data = d;
    bus.bus_write_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bus_write_en   = 1'b0;
  endtask

  task automatic chk(input string name, input int sel, input logic [11:0] a, input int exp);
    bus.bus_addr = a;
    chk_q.push_back('{name, sel, exp});
    chk_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_req = 1'b0;
  endtask

  // Start a fresh run window: the run in progress is discarded.
  task automatic arm();
    @(posedge clk);
    sync_gen++;
    run_q.delete();
  endtask

  task automatic push_run(input string name, input bit v, input int len);
    run_q.push_back('{name, v, len});
  endtask

  task automatic drain(input int bound);
    int i = 0;
    @(negedge clk);
    while (run_q.size() > 0 && i < bound) begin
      wait_tick();
      i++;
    end
    if (run_q.size() > 0) begin
      n_cmp += run_q.size();
      n_bad += run_q.size();
      $display("FAIL drain: %0d expected runs never observed", run_q.size());
      run_q.delete();
    end
  endtask

  int hi0;
  int nper;

  initial begin
    bus.bus_addr       = '0;
    bus.bus_write_en   = 1'b0;
    bus.bus_write_data = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    wait_tick();
    chk("rd_r4_reset",   0, BUZZER_R4_ADDR,   8);
    chk("rd_freq_reset", 0, BUZZER_FREQ_ADDR, 0);
    chk("rd_ctrl_reset", 0, BUZZER_CTRL_ADDR, 0);
    chk("hit_r4",        1, BUZZER_R4_ADDR,   1);
    chk("hit_ctrl",      1, BUZZER_CTRL_ADDR, 1);
    chk("miss_data",     0, 12'hF55,          0);
    chk("miss_hit",      1, 12'hF55,          0);
    chk("r4_port_reset", 3, 12'h000,          8);
    wait_ticks(100);
    chk("idle_quiet",    4, 12'h000,          0);

    // Continuous tone, P=8, then bzfq=7 after the current period
    wr(BUZZER_FREQ_ADDR, 4'd0);
    arm();
    for (int k = 0; k < 3; k++) begin
      push_run("tone8_hi", 1, 4);
      push_run("tone8_lo", 0, 4);
    end
    @(negedge clk);
    wr(BUZZER_R4_ADDR, 4'd0);
    drain(100);

    wait_level(1'b0);
    arm();
    push_run("pre_chg_hi", 1, 4);
    push_run("pre_chg_lo", 0, 4);
    push_run("tone28_hi", 1, 14);
    push_run("tone28_lo", 0, 14);
    push_run("tone28_hi", 1, 14);
    push_run("tone28_lo", 0, 14);
    wait_rise();
    wait_tick();
    wr(BUZZER_FREQ_ADDR, 4'd7);
    chk("rd_freq_7", 0, BUZZER_FREQ_ADDR, 7);
    drain(200);

    wr(BUZZER_R4_ADDR, 4'd8);
    wait_ticks(4);
    chk("stop_quiet", 2, 12'h000, 0);

    // One-shot, short then long
    wr(BUZZER_FREQ_ADDR, 4'd0);
    hi0 = hi_ticks;
    wr(BUZZER_CTRL_ADDR, 4'b1000);
    wait_tick();
    chk("shot_busy_t1", 0, BUZZER_CTRL_ADDR, 8);
    wait_ticks(1022);
    chk("shot_busy_t1023", 0, BUZZER_CTRL_ADDR, 8);
    wait_tick();
    chk("shot_done_t1024", 0, BUZZER_CTRL_ADDR, 0);
    wait_ticks(2);
    chk("shot_quiet", 2, 12'h000, 0);
    chk("shot_hi_ticks", 4, 12'h000, hi0 + 512);

    hi0 = hi_ticks;
    wr(BUZZER_CTRL_ADDR, 4'b1100);
    wait_ticks(4095);
    chk("long_busy_t4095", 0, BUZZER_CTRL_ADDR, 12);
    wait_tick();
    chk("long_done_t4096", 0, BUZZER_CTRL_ADDR, 4);
    wait_ticks(2);
    chk("long_hi_ticks", 4, 12'h000, hi0 + 2048);

    // Retrigger at tick 500
    wr(BUZZER_CTRL_ADDR, 4'b1000);
    wait_ticks(500);
    wr(BUZZER_CTRL_ADDR, 4'b1000);
    wait_ticks(1023);
    chk("retrig_busy_t1523", 0, BUZZER_CTRL_ADDR, 8);
    wait_tick();
    chk("retrig_done_t1524", 0, BUZZER_CTRL_ADDR, 0);

    // Cancel a shot by writing R43=0: busy drops, phase keeps running
    wr(BUZZER_CTRL_ADDR, 4'b1000);
    wait_ticks(20);
    wait_level(1'b0);
    arm();
    push_run("cancel_hi", 1, 4);
    push_run("cancel_lo", 0, 4);
    push_run("cancel_hi", 1, 4);
    push_run("cancel_lo", 0, 4);
    wait_rise();
    wait_tick();
    wr(BUZZER_R4_ADDR, 4'd0);
    chk("cancel_busy", 0, BUZZER_CTRL_ADDR, 0);
    drain(100);

    // Envelope, P=16, step every 2048 ticks
    wr(BUZZER_R4_ADDR, 4'd8);
    wait_ticks(4);
    wr(BUZZER_FREQ_ADDR, 4'd4);
    wr(BUZZER_CTRL_ADDR, 4'b0001);
    arm();
    for (int l = 0; l < 8; l++) begin
      nper = (l < 7) ? 128 : 4;
      for (int k = 0; k < nper; k++) begin
        push_run("env_hi", 1, 8 - l);
        push_run("env_lo", 0, 8 + l);
      end
    end
    @(negedge clk);
    wr(BUZZER_R4_ADDR, 4'd0);
    drain(15000);

    // ENRST restores full duty within the current period
    wait_level(1'b0);
    arm();
    push_run("enrst_hi", 1, 8);
    push_run("enrst_lo", 0, 8);
    push_run("enrst_hi", 1, 8);
    push_run("enrst_lo", 0, 8);
    wait_rise();
    wr(BUZZER_CTRL_ADDR, 4'b0011);
    chk("rd_ctrl_enrst", 0, BUZZER_CTRL_ADDR, 1);
    drain(100);

    // Asynchronous reset mid-tone
    wait_rise();
    chk("pre_reset_high", 2, 12'h000, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    chk("reset_buzz", 2, 12'h000, 0);
    chk("reset_r4",   3, 12'h000, 8);
    reset_n = 1'b1;
    wait_tick();
    hi0 = hi_ticks;
    wait_ticks(50);
    chk("post_reset_quiet", 4, 12'h000, hi0);
    chk("post_reset_r4",    0, BUZZER_R4_ADDR, 8);
    chk("post_reset_ctrl",  0, BUZZER_CTRL_ADDR, 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
